// File: rtl/snn_pkg.sv
// Shared types and constants for the SNN front-end sequencer (snn_frame_ctrl).
package snn_pkg;

  typedef enum logic [2:0] {
    RECV,
    UNPACK,
    START,
    WAIT_DONE,
    REPORT
  } state_t;

  localparam int NUM_PIXELS      = 784;
  localparam int PIXELS_PER_BYTE = 8;
  localparam int BYTES_PER_FRAME = NUM_PIXELS / PIXELS_PER_BYTE;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;

  // Digits 0-9 map to '0'-'9'; anything else reports '?'.
  function automatic logic [7:0] digit_to_ascii(input logic [3:0] digit);
    return (digit <= 4'd9) ? (ASCII_ZERO + {4'h0, digit}) : ASCII_ERR;
  endfunction

endpackage

// File: rtl/snn_byte_unpacker.sv
// Shift register plus bit counter: turns one loaded byte into BYTE_W
// consecutive LSB-first pixel strobes.
module snn_byte_unpacker #(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [BYTE_W-1:0] din,
  output logic              bit_valid,
  output logic              bit_data,
  output logic              last_bit
);

  localparam int CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;

  logic [BYTE_W-1:0] shift_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              active_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q  <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      shift_q  <= din;
      cnt_q    <= '0;
      active_q <= 1'b1;
    end else if (active_q) begin
      shift_q <= shift_q >> 1;
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_bit) active_q <= 1'b0;
    end
  end

  assign bit_valid = active_q;
  assign bit_data  = active_q & shift_q[0];
  assign last_bit  = active_q && (cnt_q == CNT_W'(BYTE_W - 1));

endmodule

// File: rtl/snn_frame_ctrl.sv
// Frame sequencer: unpacks received bytes into the pixel RAM, kicks snn_core,
// and reports the classified digit as ASCII. Optional SNN_TIMEOUT_EN adds a
// WAIT_DONE watchdog that reports '?' after TIMEOUT_CYC cycles.
module snn_frame_ctrl #(
  parameter int NUM_PIXELS  = snn_pkg::NUM_PIXELS,
  parameter int ADDR_W      = 10,
  parameter int BYTE_W      = snn_pkg::PIXELS_PER_BYTE,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx_rdy,
  input  logic [BYTE_W-1:0] rx_data,
  output logic              rx_clr,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  input  logic              tx_rdy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        digit_out,
  output logic              result_valid,
  output logic              busy
);

  import snn_pkg::*;

  if ((NUM_PIXELS % BYTE_W) != 0 || NUM_PIXELS > (1 << ADDR_W) || TIMEOUT_CYC < 1)
  begin : g_cfg_err
    $error("snn_frame_ctrl: inconsistent NUM_PIXELS/BYTE_W/ADDR_W/TIMEOUT_CYC");
  end

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        digit_q;
  logic [7:0]        tx_data_q;
  logic              result_valid_q;

  logic              load;
  logic              bit_valid, bit_data, last_bit;
  logic              frame_end;
  logic              timeout_hit;
  logic              report_go;
  logic [3:0]        report_digit;

  assign load      = (state_q == RECV) && rx_rdy;
  assign frame_end = last_bit && (addr_q == ADDR_W'(NUM_PIXELS - 1));

  snn_byte_unpacker #(.BYTE_W(BYTE_W)) u_unpacker (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (rx_data),
    .bit_valid (bit_valid),
    .bit_data  (bit_data),
    .last_bit  (last_bit)
  );

`ifdef SNN_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0] tmo_q;

  // Runs only while waiting, so it is already clear on every WAIT_DONE entry.
  always_ff @(posedge clk) begin
    if (rst || state_q != WAIT_DONE) tmo_q <= '0;
    else                             tmo_q <= tmo_q + TMO_W'(1);
  end

  assign timeout_hit = (state_q == WAIT_DONE) && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // A real done always wins over a simultaneous watchdog expiry.
  assign report_go    = (state_q == WAIT_DONE) && (core_done || timeout_hit);
  assign report_digit = core_done ? core_digit : 4'hF;

  always_ff @(posedge clk) begin
    if (rst) state_q <= RECV;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RECV:      if (rx_rdy)    state_d = UNPACK;
      UNPACK:    if (last_bit)  state_d = frame_end ? START : RECV;
      START:                    state_d = WAIT_DONE;
      WAIT_DONE: if (report_go) state_d = REPORT;
      REPORT:    if (tx_rdy)    state_d = RECV;
      default:                  state_d = RECV;
    endcase
  end

  // NOTE: every output gets a value on every path through this block;
  // a missing default in combinational logic would infer a latch.
  always_comb begin
    rx_clr       = (state_q == RECV) && rx_rdy;
    ram_we       = bit_valid;
    ram_addr     = addr_q;
    ram_data     = bit_data;
    core_start   = (state_q == START);
    tx_start     = (state_q == REPORT) && tx_rdy;
    tx_data      = tx_data_q;
    digit_out    = digit_q;
    result_valid = result_valid_q;
    busy         = (state_q != RECV);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      digit_q        <= '0;
      tx_data_q      <= '0;
      result_valid_q <= 1'b0;
    end else begin
      if (state_q == UNPACK) addr_q <= frame_end ? '0 : addr_q + ADDR_W'(1);
      if (state_q == START)  addr_q <= '0;

      if (report_go) begin
        digit_q   <= report_digit;
        tx_data_q <= digit_to_ascii(report_digit);
      end

      // Address 0 in RECV means the accepted byte opens a new frame.
      if (tx_start)                  result_valid_q <= 1'b1;
      else if (load && addr_q == '0) result_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_snn_frame_ctrl.sv
// Self-checking bench for snn_frame_ctrl: a pixel/frame model checks every RAM
// write, start pulse and transmit byte; directed steps pin the reported values.
`timescale 1ns/1ps
module tb_snn_frame_ctrl;

  localparam int NPIX   = 784;
  localparam int NBYTES = snn_pkg::BYTES_PER_FRAME;

  logic       clk = 1'b0;
  logic       rst, rx_rdy, core_done, tx_rdy;
  logic [7:0] rx_data;
  logic [3:0] core_digit;
  logic       rx_clr, ram_we, ram_data, core_start, tx_start, result_valid, busy;
  logic [9:0] ram_addr;
  logic [7:0] tx_data;
  logic [3:0] digit_out;

  always #5 clk = ~clk;

  snn_frame_ctrl #(
    .NUM_PIXELS(NPIX), .ADDR_W(10), .BYTE_W(8), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_clr(rx_clr),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data),
    .core_start(core_start), .core_done(core_done), .core_digit(core_digit),
    .tx_rdy(tx_rdy), .tx_start(tx_start), .tx_data(tx_data),
    .digit_out(digit_out), .result_valid(result_valid), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame content model: byte k of frame 'seed'; pixel n is bit n%8 of byte n/8.
  function automatic logic [7:0] frame_byte(input int seed, input int k);
    if (seed == 0) return 8'hA5;
    return 8'((k * 37 + seed * 11) & 255);
  endfunction

  function automatic logic pixel(input int seed, input int n);
    logic [7:0] b;
    b = frame_byte(seed, n / 8);
    return b[n % 8];
  endfunction

  // Shared between stimulus (writer) and monitor (reader).
  int         cur_seed = 0;
  logic [7:0] exp_tx   = 8'h00;

  // Monitor-owned state.
  int         cyc = 0, exp_addr = 0, final_cyc = -10;
  int         n_we = 0, n_clr = 0, n_start = 0, n_tx = 0;
  int         start_cyc = 0, tx_cyc = 0;
  logic [7:0] first_pix = 8'h00;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      exp_addr = 0;
    end else begin
      if (ram_we) begin
        check("ram_addr", 32'(ram_addr), exp_addr);
        check("ram_data", 32'(ram_data), 32'(pixel(cur_seed, exp_addr)));
        if (cur_seed == 0 && exp_addr < 8) first_pix[exp_addr] = ram_data;
        n_we++;
        if (exp_addr == NPIX - 1) begin
          final_cyc = cyc;
          exp_addr  = 0;
        end else begin
          exp_addr++;
        end
      end
      if (core_start) begin
        check("core_start_after_last_write", 32'(cyc - final_cyc), 1);
        n_start++;
        start_cyc = cyc;
      end
      if (tx_start) begin
        check("tx_data_on_pulse", 32'(tx_data), 32'(exp_tx));
        n_tx++;
        tx_cyc = cyc;
      end
      if (rx_clr) n_clr++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({rx_clr, ram_we, ram_addr, ram_data, core_start, tx_start,
                tx_data, digit_out, result_valid, busy});
  endfunction

  // Sends a frame with rx_rdy held; abort_at >= 0 resets mid-UNPACK of that byte.
  task automatic send_frame(input int seed, input int abort_at, input bit check_rv);
    cur_seed = seed;
    for (int k = 0; k < NBYTES; k++) begin
      bit got;
      got     = 1'b0;
      rx_data = frame_byte(seed, k);
      rx_rdy  = 1'b1;
      for (int t = 0; t < 40 && !got; t++) begin
        @(negedge clk);
        if (rx_clr) got = 1'b1;
      end
      if (!got) begin
        check("rx_clr_timeout", 0, 1);
        rx_rdy = 1'b0;
        return;
      end
      tick();
      if (k == 0 && check_rv) begin
        @(negedge clk);
        check("result_valid_cleared_by_first_byte", 32'(result_valid), 0);
        tick();
      end
      if (k == abort_at) begin
        tick();
        rst    = 1'b1;
        rx_rdy = 1'b0;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("outputs_after_midframe_reset", all_outputs(), 0);
        tick();
        return;
      end
    end
    rx_rdy = 1'b0;
  endtask

  task automatic wait_start();
    bit got;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (core_start) got = 1'b1;
    end
    if (!got) check("core_start_timeout", 0, 1);
    #1;
  endtask

  task automatic wait_tx(input int limit);
    bit got;
    got = 1'b0;
    for (int t = 0; t < limit && !got; t++) begin
      @(negedge clk);
      if (tx_start) got = 1'b1;
    end
    if (!got) check("tx_start_timeout", 0, 1);
    #1;
  endtask

  int we0, clr0, st0, tx0;

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00;
    core_done = 1'b0; core_digit = 4'h0; tx_rdy = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", all_outputs(), 0);
    tick();

    // Frame 1: 98 x A5, gapless.
    we0 = n_we; clr0 = n_clr; st0 = n_start;
    send_frame(0, -1, 1'b0);
    wait_start();
    check("frame1_ram_writes", 32'(n_we - we0), 784);
    check("frame1_rx_clr_pulses", 32'(n_clr - clr0), 98);
    check("frame1_core_starts", 32'(n_start - st0), 1);
    check("frame1_first_pixels", 32'(first_pix), 32'h0000_00A5);
    tick();
    @(negedge clk);
    check("core_start_single_cycle", 32'(core_start), 0);
    check("busy_in_wait", 32'(busy), 1);

    // Bytes offered while waiting for done must stay pending.
    tick();
    clr0 = n_clr;
    rx_data = 8'hFF; rx_rdy = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("wait_done_ignores_rx", 32'(n_clr - clr0), 0);
    tick();
    rx_rdy = 1'b0;

    core_digit = 4'd7; core_done = 1'b1; tx_rdy = 1'b1; exp_tx = 8'h37;
    wait_tx(10);
    check("tx_data_digit7", 32'(tx_data), 32'h37);
    check("digit_out_7", 32'(digit_out), 7);
    tick();
    core_done = 1'b0;
    @(negedge clk);
    check("result_valid_set", 32'(result_valid), 1);
    check("tx_start_single", 32'(tx_start), 0);
    check("idle_not_busy", 32'(busy), 0);
    check("tx_data_holds", 32'(tx_data), 32'h37);
    tick();

    // Frame 2: digit C while transmitter is busy for 20 cycles.
    send_frame(1, -1, 1'b1);
    wait_start();
    tick();
    core_digit = 4'hC; core_done = 1'b1; tx_rdy = 1'b0; exp_tx = 8'h3F;
    tx0 = n_tx;
    repeat (20) @(negedge clk);
    #1;
    check("no_tx_while_tx_rdy_low", 32'(n_tx - tx0), 0);
    check("busy_in_report", 32'(busy), 1);
    check("digit_out_C", 32'(digit_out), 32'hC);
    tick();
    tx_rdy = 1'b1; core_done = 1'b0;
    @(negedge clk);
    check("tx_start_first_rdy_cycle", 32'(tx_start), 1);
    check("tx_data_err", 32'(tx_data), 32'h3F);
    tick();
    @(negedge clk);
    #1;
    check("tx_single_pulse_after_wait", 32'(n_tx - tx0), 1);
    tick();

    // Frame 3 aborted by reset during byte 40, then a fresh full frame.
    send_frame(2, 40, 1'b0);
    we0 = n_we; st0 = n_start;
    send_frame(3, -1, 1'b0);
    wait_start();
    check("fresh_frame_ram_writes", 32'(n_we - we0), 784);
    check("fresh_frame_core_starts", 32'(n_start - st0), 1);
    tick();
    core_digit = 4'd3; core_done = 1'b1; exp_tx = 8'h33;
    wait_tx(10);
    check("tx_data_digit3", 32'(tx_data), 32'h33);
    tick();
    core_done = 1'b0;
    tick();

    // Frame 4: core_done never arrives.
    send_frame(4, -1, 1'b0);
    wait_start();
    tx0 = n_tx;
`ifdef SNN_TIMEOUT_EN
    exp_tx = 8'h3F;
    wait_tx(200);
    check("timeout_latency", 32'(tx_cyc - start_cyc), 101);
    check("timeout_tx_data", 32'(tx_data), 32'h3F);
    check("timeout_digit_F", 32'(digit_out), 32'hF);
`else
    repeat (150) @(negedge clk);
    #1;
    check("waits_without_done", 32'(n_tx - tx0), 0);
    check("still_busy_without_done", 32'(busy), 1);
    tick();
    core_digit = 4'd9; core_done = 1'b1; exp_tx = 8'h39;
    wait_tx(10);
    check("tx_data_digit9", 32'(tx_data), 32'h39);
`endif
    tick();
    core_done = 1'b0;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
